// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared entry/commit types and default widths for the reorder buffer
// ROB_MACROOP_ATOMIC_EN adds macro-op boundary bits to each entry.
package rob_pkg;

  localparam int ROB_ENTRIES_D  = 16;
  localparam int ISSUE_WIDTH_D  = 2;
  localparam int COMMIT_WIDTH_D = 2;
  localparam int WB_PORTS_D     = 3;
  localparam int AREG_BITS_D    = 4;
  localparam int PREG_BITS_D    = 6;
  localparam int TAG_BITS_D     = 2;

  typedef struct packed {
    logic                   valid;
    logic                   busy;
    logic                   exception;
`ifdef ROB_MACROOP_ATOMIC_EN
    logic                   mop_start;
    logic                   mop_end;
`endif
    logic [AREG_BITS_D-1:0] areg;
    logic [PREG_BITS_D-1:0] preg;
    logic [PREG_BITS_D-1:0] old_preg;
    logic [TAG_BITS_D-1:0]  tag;
  } rob_entry_t;

  typedef struct packed {
    logic [AREG_BITS_D-1:0] areg;
    logic [PREG_BITS_D-1:0] preg;
    logic [PREG_BITS_D-1:0] free_preg;
  } commit_t;

endpackage

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - in-order ready-prefix scan over the head window
// ROB_MACROOP_ATOMIC_EN trims the prefix back to the last completed macro-op end.
module rob_commit_select #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_BITS     = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0] done_i,
`ifdef ROB_MACROOP_ATOMIC_EN
  input  logic [COMMIT_WIDTH-1:0] mop_end_i,
`endif
  output logic [COMMIT_WIDTH-1:0] retire_mask_o,
  output logic [CNT_BITS-1:0]     retire_cnt_o
);

  logic [COMMIT_WIDTH-1:0] prefix;
  logic                    run;
`ifdef ROB_MACROOP_ATOMIC_EN
  logic                    cut_ok;
`endif

  always_comb begin
    prefix        = '0;
    retire_mask_o = '0;
    retire_cnt_o  = '0;
    run           = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run       = run & done_i[k];
      prefix[k] = run;
    end
`ifdef ROB_MACROOP_ATOMIC_EN
    // A slot may retire only if some slot at or after it (still in the prefix) closes its group.
    cut_ok = 1'b0;
    for (int k = COMMIT_WIDTH - 1; k >= 0; k--) begin
      if (prefix[k] && mop_end_i[k]) cut_ok = 1'b1;
      retire_mask_o[k] = cut_ok & prefix[k];
    end
`else
    retire_mask_o = prefix;
`endif
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      retire_cnt_o = retire_cnt_o + CNT_BITS'(retire_mask_o[k]);
    end
  end

endmodule

// File: rtl/rob_ring.sv
// rtl/rob_ring.sv - circular reorder buffer: N-wide alloc/writeback/commit, tag squash, precise exception
// ROB_MACROOP_ATOMIC_EN enables atomic macro-op group retirement.
module rob_ring
  import rob_pkg::*;
#(
  parameter int ROB_ENTRIES  = ROB_ENTRIES_D,
  parameter int ISSUE_WIDTH  = ISSUE_WIDTH_D,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_D,
  parameter int WB_PORTS     = WB_PORTS_D,
  parameter int AREG_BITS    = AREG_BITS_D,
  parameter int PREG_BITS    = PREG_BITS_D,
  parameter int TAG_BITS     = TAG_BITS_D,
  parameter int IDX_BITS     = $clog2(ROB_ENTRIES)
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [ISSUE_WIDTH-1:0]            alloc_valid_i,
  input  logic [ISSUE_WIDTH*AREG_BITS-1:0]  alloc_areg_i,
  input  logic [ISSUE_WIDTH*PREG_BITS-1:0]  alloc_preg_i,
  input  logic [ISSUE_WIDTH*PREG_BITS-1:0]  alloc_old_preg_i,
  input  logic [ISSUE_WIDTH*TAG_BITS-1:0]   alloc_tag_i,
  input  logic [ISSUE_WIDTH-1:0]            alloc_zerocycle_i,
`ifdef ROB_MACROOP_ATOMIC_EN
  input  logic [ISSUE_WIDTH-1:0]            alloc_macroop_start_i,
  input  logic [ISSUE_WIDTH-1:0]            alloc_macroop_end_i,
`endif
  output logic                              alloc_ready_o,
  output logic [ISSUE_WIDTH*IDX_BITS-1:0]   alloc_idx_o,
  input  logic [WB_PORTS-1:0]               wb_valid_i,
  input  logic [WB_PORTS*IDX_BITS-1:0]      wb_idx_i,
  input  logic [WB_PORTS-1:0]               wb_exception_i,
  input  logic                              shootdown_i,
  input  logic [TAG_BITS-1:0]               shootdown_tag_i,
  output logic [COMMIT_WIDTH-1:0]           commit_valid_o,
  output logic [COMMIT_WIDTH*AREG_BITS-1:0] commit_areg_o,
  output logic [COMMIT_WIDTH*PREG_BITS-1:0] commit_preg_o,
  output logic [COMMIT_WIDTH*PREG_BITS-1:0] commit_free_preg_o,
  output logic                              exc_valid_o,
  output logic [IDX_BITS:0]                 free_count_o,
  output logic                              empty_o,
  output logic                              full_o
);

  localparam int CNT_BITS = IDX_BITS + 1;
  localparam int RET_BITS = $clog2(COMMIT_WIDTH + 1);
  localparam logic [CNT_BITS-1:0] DEPTH = CNT_BITS'(ROB_ENTRIES);

  rob_entry_t              entries_q [ROB_ENTRIES];
  rob_entry_t              entries_d [ROB_ENTRIES];
  logic [IDX_BITS-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]     count_q, count_d;
  logic [COMMIT_WIDTH-1:0] commit_valid_q, commit_valid_d;
  commit_t                 commit_q [COMMIT_WIDTH];
  commit_t                 commit_d [COMMIT_WIDTH];
  logic                    exc_valid_q, exc_valid_d;

  logic [CNT_BITS-1:0]     n_alloc, n_squash, free_count;
  logic                    exc_pending;
  logic [ROB_ENTRIES-1:0]  squash;
  logic [COMMIT_WIDTH-1:0] win_done, retire_mask;
  logic [RET_BITS-1:0]     retire_cnt;

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) n_alloc = n_alloc + CNT_BITS'(alloc_valid_i[i]);
  end

  assign free_count  = DEPTH - count_q;
  assign exc_pending = entries_q[head_q].valid & ~entries_q[head_q].busy & entries_q[head_q].exception;
  // free_count is the pre-edge value, so same-cycle retirement never frees room for this allocation.
  assign alloc_ready_o = (n_alloc <= free_count) & ~shootdown_i & ~exc_pending;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_alloc_idx
    assign alloc_idx_o[i*IDX_BITS +: IDX_BITS] = tail_q + IDX_BITS'(i);
  end

  always_comb begin
    squash   = '0;
    n_squash = '0;
    for (int e = 0; e < ROB_ENTRIES; e++) begin
      squash[e] = shootdown_i & ~exc_pending & entries_q[e].valid &
                  (entries_q[e].tag != '0) & (entries_q[e].tag >= shootdown_tag_i);
      n_squash  = n_squash + CNT_BITS'(squash[e]);
    end
  end

  always_comb begin
    win_done = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      win_done[k] = entries_q[head_q + IDX_BITS'(k)].valid & ~entries_q[head_q + IDX_BITS'(k)].busy &
                    ~entries_q[head_q + IDX_BITS'(k)].exception & ~squash[head_q + IDX_BITS'(k)];
    end
  end

`ifdef ROB_MACROOP_ATOMIC_EN
  logic [COMMIT_WIDTH-1:0] win_end;
  logic                    group_overflow;

  always_comb begin
    win_end        = '0;
    group_overflow = entries_q[head_q].valid & entries_q[head_q].mop_start;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      win_end[k] = entries_q[head_q + IDX_BITS'(k)].mop_end;
      if (!entries_q[head_q + IDX_BITS'(k)].valid || win_end[k]) group_overflow = 1'b0;
    end
  end

  assert property (@(posedge clk_i) disable iff (!reset_ni) !group_overflow)
    else $fatal(1, "macro-op group longer than the commit window");
`endif

  rob_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_BITS     (RET_BITS)
  ) u_commit_select (
    .done_i        (win_done),
`ifdef ROB_MACROOP_ATOMIC_EN
    .mop_end_i     (win_end),
`endif
    .retire_mask_o (retire_mask),
    .retire_cnt_o  (retire_cnt)
  );

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = '0;
    exc_valid_d    = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) commit_d[k] = '0;

    if (exc_pending) begin
      for (int e = 0; e < ROB_ENTRIES; e++) entries_d[e].valid = 1'b0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      exc_valid_d = 1'b1;
    end else begin
      for (int e = 0; e < ROB_ENTRIES; e++) begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid_i[p] && entries_q[e].valid &&
              wb_idx_i[p*IDX_BITS +: IDX_BITS] == IDX_BITS'(e)) begin
            entries_d[e].busy      = 1'b0;
            entries_d[e].exception = entries_d[e].exception | wb_exception_i[p];
          end
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (retire_mask[k]) begin
          entries_d[head_q + IDX_BITS'(k)].valid = 1'b0;
          commit_valid_d[k]     = 1'b1;
          commit_d[k].areg      = entries_q[head_q + IDX_BITS'(k)].areg;
          commit_d[k].preg      = entries_q[head_q + IDX_BITS'(k)].preg;
          commit_d[k].free_preg = entries_q[head_q + IDX_BITS'(k)].old_preg;
        end
      end
      for (int e = 0; e < ROB_ENTRIES; e++) begin
        if (squash[e]) entries_d[e].valid = 1'b0;
      end
      if (alloc_ready_o) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          if (alloc_valid_i[i]) begin
            entries_d[tail_q + IDX_BITS'(i)].valid     = 1'b1;
            entries_d[tail_q + IDX_BITS'(i)].busy      = ~alloc_zerocycle_i[i];
            entries_d[tail_q + IDX_BITS'(i)].exception = 1'b0;
            entries_d[tail_q + IDX_BITS'(i)].areg      = alloc_areg_i[i*AREG_BITS +: AREG_BITS];
            entries_d[tail_q + IDX_BITS'(i)].preg      = alloc_preg_i[i*PREG_BITS +: PREG_BITS];
            entries_d[tail_q + IDX_BITS'(i)].old_preg  = alloc_old_preg_i[i*PREG_BITS +: PREG_BITS];
            entries_d[tail_q + IDX_BITS'(i)].tag       = alloc_tag_i[i*TAG_BITS +: TAG_BITS];
`ifdef ROB_MACROOP_ATOMIC_EN
            entries_d[tail_q + IDX_BITS'(i)].mop_start = alloc_macroop_start_i[i];
            entries_d[tail_q + IDX_BITS'(i)].mop_end   = alloc_macroop_end_i[i];
`endif
          end
        end
      end
      // Squashed entries are the youngest contiguous run, so the tail simply retracts.
      head_d  = head_q + IDX_BITS'(retire_cnt);
      tail_d  = tail_q + (alloc_ready_o ? n_alloc[IDX_BITS-1:0] : '0) - n_squash[IDX_BITS-1:0];
      count_d = count_q + (alloc_ready_o ? n_alloc : '0) - CNT_BITS'(retire_cnt) - n_squash;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      entries_q      <= '{default: '0};
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= '0;
      commit_q       <= '{default: '0};
      exc_valid_q    <= 1'b0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_q       <= commit_d;
      exc_valid_q    <= exc_valid_d;
    end
  end

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_commit_out
    assign commit_areg_o[k*AREG_BITS +: AREG_BITS]      = commit_q[k].areg;
    assign commit_preg_o[k*PREG_BITS +: PREG_BITS]      = commit_q[k].preg;
    assign commit_free_preg_o[k*PREG_BITS +: PREG_BITS] = commit_q[k].free_preg;
  end

  assign commit_valid_o = commit_valid_q;
  assign exc_valid_o    = exc_valid_q;
  assign free_count_o   = free_count;
  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == DEPTH);

endmodule
